// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - MIPS fetch stage: PC, IF/ID register, redirects, stall, HALT
// IF/ID is a plain register set; fetch stops for good once HALT_INSTR has been latched.
module instruction_fetch #(
    parameter int          NB_DATA      = 32,
    parameter int          NB_PC        = 32,
    parameter int          NB_IMEM_ADDR = 10,
    parameter int          NB_COUNT     = 32,
    parameter logic [31:0] HALT_INSTR   = 32'hFFFF_FFFF
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_enable,
    input  logic                    i_stall,
    input  logic                    i_branch_taken,
    input  logic [NB_PC-1:0]        i_branch_target,
    input  logic                    i_jump,
    input  logic [NB_PC-1:0]        i_jump_target,
    input  logic [NB_DATA-1:0]      i_imem_data,
    output logic [NB_IMEM_ADDR-1:0] o_imem_addr,
    output logic [NB_DATA-1:0]      o_instruction,
    output logic [NB_PC-1:0]        o_pc_plus4,
    output logic                    o_valid,
    output logic                    o_halt,
    output logic [NB_COUNT-1:0]     o_fetch_count
);

    typedef enum logic [0:0] {RUN, HALTED} state_t;

    state_t                state_q, state_d;
    logic [NB_PC-1:0]      pc_q, pc_d;
    logic [NB_DATA-1:0]    instr_q, instr_d;
    logic [NB_PC-1:0]      pc_plus4_q, pc_plus4_d;
    logic                  valid_q, valid_d;
    logic [NB_COUNT-1:0]   count_q, count_d;
    logic [NB_PC-1:0]      pc_plus4;
    logic                  step;

    assign pc_plus4 = pc_q + NB_PC'(4);
    assign step     = i_enable && !i_stall;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= RUN;
            pc_q       <= '0;
            instr_q    <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        count_d    = count_q;
        if (step) begin
            case (state_q)
                RUN: begin
                    if (i_jump || i_branch_taken) begin
                        // Jump has priority over a simultaneous taken branch.
                        pc_d       = i_jump ? i_jump_target : i_branch_target;
                        instr_d    = '0;
                        pc_plus4_d = '0;
                        valid_d    = 1'b0;
                    end else begin
                        instr_d    = i_imem_data;
                        pc_plus4_d = pc_plus4;
                        valid_d    = 1'b1;
                        count_d    = count_q + NB_COUNT'(1);
                        if (i_imem_data == NB_DATA'(HALT_INSTR)) begin
                            state_d = HALTED;
                        end else begin
                            pc_d = pc_plus4;
                        end
                    end
                end
                HALTED: begin
                    // Keep feeding bubbles so the HALT word drains through the pipe.
                    instr_d    = '0;
                    pc_plus4_d = '0;
                    valid_d    = 1'b0;
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign o_imem_addr   = pc_q[NB_IMEM_ADDR+1:2];
    assign o_instruction = instr_q;
    assign o_pc_plus4    = pc_plus4_q;
    assign o_valid       = valid_q;
    assign o_halt        = (state_q == HALTED);
    assign o_fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch
// Reference model steps a behavioural PC/halt machine; a monitor compares each edge's outputs.
module tb_instruction_fetch;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, stall, br, jmp;
    logic [31:0] bt, jt;
    logic [31:0] imem_data;
    logic [9:0]  imem_addr;
    logic [31:0] instr, pc_plus4, fetch_count;
    logic        valid, halt;

    logic [31:0] mem [1024];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] p4;
        logic        valid;
        logic        halt;
        logic [31:0] cnt;
        logic [9:0]  addr;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int failures = 0;

    // Behavioural reference state
    logic [31:0] m_pc, m_instr, m_p4, m_cnt;
    logic        m_valid, m_halted;

    instruction_fetch dut (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_enable       (enable),
        .i_stall        (stall),
        .i_branch_taken (br),
        .i_branch_target(bt),
        .i_jump         (jmp),
        .i_jump_target  (jt),
        .i_imem_data    (imem_data),
        .o_imem_addr    (imem_addr),
        .o_instruction  (instr),
        .o_pc_plus4     (pc_plus4),
        .o_valid        (valid),
        .o_halt         (halt),
        .o_fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;
    assign imem_data = mem[imem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_instr = 0; m_p4 = 0; m_cnt = 0; m_valid = 0; m_halted = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_addr"}, 32'(imem_addr), 32'h0);
        chk({tag, "_instr"}, instr, 32'h0);
        chk({tag, "_p4"}, pc_plus4, 32'h0);
        chk({tag, "_valid"}, 32'(valid), 32'h0);
        chk({tag, "_halt"}, 32'(halt), 32'h0);
        chk({tag, "_count"}, fetch_count, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock edge: drive inputs, advance the reference model, queue its prediction.
    task automatic step(input bit en, input bit st, input bit b, input logic [31:0] btg,
                        input bit j, input logic [31:0] jtg);
        logic [31:0] w;
        exp_t e;
        enable = en; stall = st; br = b; bt = btg; jmp = j; jt = jtg;
        if (en && !st) begin
            if (m_halted) begin
                m_instr = 0; m_p4 = 0; m_valid = 0;
            end else if (j || b) begin
                m_pc = j ? jtg : btg;
                m_instr = 0; m_p4 = 0; m_valid = 0;
            end else begin
                w = mem[m_pc[11:2]];
                m_instr = w;
                m_p4 = m_pc + 4;
                m_valid = 1;
                m_cnt = m_cnt + 1;
                if (w == HALT) m_halted = 1;
                else m_pc = m_pc + 4;
            end
        end
        e.instr = m_instr; e.p4 = m_p4; e.valid = m_valid; e.halt = m_halted;
        e.cnt = m_cnt; e.addr = m_pc[11:2];
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic adv();
        step(1, 0, 0, 0, 0, 0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("instr", instr, e.instr);
            chk("pc_plus4", pc_plus4, e.p4);
            chk("valid", 32'(valid), 32'(e.valid));
            chk("halt", 32'(halt), 32'(e.halt));
            chk("fetch_count", fetch_count, e.cnt);
            chk("imem_addr", 32'(imem_addr), 32'(e.addr));
        end
    end

    initial begin
        enable = 0; stall = 0; br = 0; jmp = 0; bt = 0; jt = 0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom & 32'h7FFF_FFFF;
        mem[0] = 32'h2001_0005;
        mem[1] = 32'h2002_0007;
        mem[2] = 32'h0022_1820;

        do_reset();

        // Sequential fetch, then a 3-cycle stall at pc 8
        adv(); adv();
        chk("pre_stall_p4", pc_plus4, 32'd8);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        chk("stall_addr", 32'(imem_addr), 32'd2);
        adv();
        chk("post_stall_instr", instr, 32'h0022_1820);
        chk("post_stall_count", fetch_count, 32'd3);

        // Redirects
        step(1, 0, 0, 0, 1, 32'h10);
        step(1, 0, 1, 32'h40, 0, 0);
        chk("branch_bubble", 32'(valid), 32'h0);
        chk("branch_addr", 32'(imem_addr), 32'h10);
        adv();
        chk("branch_p4", pc_plus4, 32'h44);
        step(1, 1, 1, 32'h300, 1, 32'h200);
        step(1, 0, 1, 32'h40, 1, 32'h80);
        chk("jump_wins_addr", 32'(imem_addr), 32'h20);

        // Enable pattern 1,0,0,1 with redirect noise on disabled cycles
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h500, 0, 0);
        step(0, 0, 0, 0, 1, 32'h600);
        step(1, 0, 0, 0, 0, 0);

        // Random traffic (memory holds no HALT word here)
        for (int n = 0; n < 400; n++) begin
            bit en, st, b, j;
            en = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 4) == 0);
            b  = ($urandom_range(0, 9) == 0);
            j  = ($urandom_range(0, 9) == 0);
            step(en, st, b, $urandom & 32'hFFFF_FFFC, j, $urandom & 32'hFFFF_FFFC);
        end

        // HALT at address 5
        do_reset();
        mem[5] = HALT;
        for (int n = 0; n < 6; n++) adv();
        chk("halt_flag", 32'(halt), 32'h1);
        chk("halt_instr", instr, HALT);
        chk("halt_addr", 32'(imem_addr), 32'h5);
        adv();
        chk("halt_bubble", 32'(valid), 32'h0);
        for (int n = 0; n < 30; n++) begin
            step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 32'h40, $urandom_range(0, 1), 32'h80);
        end
        chk("halt_count_frozen", fetch_count, 32'd6);

        // Async reset while halted at 0x1C
        do_reset();
        mem[5] = 32'h0000_0000;
        mem[7] = HALT;
        for (int n = 0; n < 9; n++) adv();
        chk("halt7_addr", 32'(imem_addr), 32'h7);
        chk("halt7_flag", 32'(halt), 32'h1);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        adv();
        chk("after_reset_instr", instr, 32'h2001_0005);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
